sr_ff_arbiter: RTL
==================

Name: sr_ff_arbiter

Overview:
Round-robin arbiter and sequencer that shares one bank of WIDTH SR flip-flops among NREQ requesters. Each requester asks to set or clear a masked group of bits. The arbiter grants one requester at a time and drives registered, never-illegal s/r vectors (s&r never 11) into the bank. When the optional check is compiled in, it reads back the bank's q to confirm the operation. It sits between the control agents and the SR register bank, and shares clk/res with the bank.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, width of the SR bank / mask

Ports:
clk     input   1             rising-edge clock
res     input   1             synchronous active-high reset; also drives the bank's reset
req     input   NREQ          per-requester request level
op_set  input   NREQ          per-requester op: 1 = set masked bits, 0 = clear masked bits
mask    input   NREQ*WIDTH    requester i's mask at mask[i*WIDTH +: WIDTH]
q_in    input   WIDTH         readback of SR bank q
gnt     output  NREQ          one-hot grant, registered
ack     output  NREQ          one-cycle completion pulse to granted requester
s_out   output  WIDTH         set vector to bank, registered
r_out   output  WIDTH         reset vector to bank, registered
busy    output  1             high whenever FSM is not IDLE
err     output  1             readback mismatch flag (see Optional Feature)

Behaviour:
- Reset (synchronous, res=1 at a rising edge):
  - FSM goes to IDLE.
  - gnt, ack, s_out, r_out and err all go to 0.
  - Round-robin pointer goes to 0.
  - Takes effect from any state; an in-flight op is abandoned with no ack.
- FSM states: IDLE, ISSUE, CHECK (CHECK exists only with the macro).
- IDLE:
  - If any req bit is set, select the winner k at the edge.
  - Search starts at the pointer and moves upward modulo NREQ; the first set bit wins.
  - At that edge: gnt <= onehot(k); s_out <= op_set[k] ? mask_k : 0; r_out <= op_set[k] ? 0 : mask_k; pointer <= (k+1) mod NREQ; go to ISSUE.
  - If no req bit is set, stay in IDLE with all outputs 0.
- ISSUE (exactly 1 cycle):
  - s_out/r_out are stable; the bank captures them at the end of this cycle.
  - Next-state edge: s_out, r_out <= 0; go to CHECK (macro) or IDLE (no macro). gnt is held into CHECK.
- CHECK (1 cycle, macro only):
  - q_in reflects the completed op; ack[k] and err are evaluated here.
  - Next edge: gnt <= 0; go to IDLE.
- ack[k] is high only during the final state cycle of an op (CHECK with the macro, ISSUE without it). It is a decode of state and gnt, with no extra register delay.
- Requester contract:
  - Hold req, op_set and mask stable from assertion until the ack cycle.
  - Deassert req at the edge ending the ack cycle.
  - A requester that keeps req high simply re-competes; the rotated pointer gives the others priority first.
- Latency, req to ack:
  - 2 cycles with macro: req seen in IDLE cycle 0, ISSUE cycle 1, CHECK/ack cycle 2.
  - 1 cycle without macro: ack in cycle 1.
  - Throughput: one op per 3 (macro) / 2 (no macro) cycles.
- An all-zero mask is still granted: it drives s=r=0 (bank holds), is acked, and the check passes.
- By construction s_out & r_out == 0 in every cycle.
- busy = (state != IDLE).

Optional Feature:
Macro SR_ARB_READBACK_EN.
- Defined:
  - CHECK state is present.
  - During CHECK, err = 1 if (op_set[k] ? ((q_in & mask_k) != mask_k) : ((q_in & mask_k) != 0)), else 0.
  - err is 0 outside CHECK.
- Not defined:
  - No CHECK state; ISSUE returns directly to IDLE.
  - err is tied to 0.
  - q_in is ignored.

Test Plan:
- Single set (macro on): NREQ=4, WIDTH=8; req0=1, op_set0=1, mask0=0xA5, bank starts at 0. Required: gnt=0001 and s_out=0xA5, r_out=0x00 in cycle 1; q_in=0xA5 in cycle 2; ack=0001 in cycle 2, err=0; busy high in cycles 1-2.
- Clear: bank at 0xFF; req2, op_set2=0, mask2=0x0F. Required: r_out=0x0F and s_out=0x00 for 1 cycle; q_in becomes 0xF0; ack[2] pulse; err=0.
- Round robin: all four req held continuously, pointer at 0. Required: grant order 0,1,2,3,0; exactly one gnt bit high at a time; each ack 3 cycles apart.
- Readback error: tie q_in to 0x00 during a set of mask 0x3C. Required: err=1 in the CHECK cycle only, ack still pulses, FSM returns to IDLE.
- Reset mid-op: assert res during ISSUE. Required: next cycle state IDLE, s_out=r_out=0, gnt=0, no ack, pointer=0; the next req3 is served normally.
- Macro off: repeat the single-set scenario. Required: ack in cycle 1 (same cycle as ISSUE), err constantly 0, back-to-back ops every 2 cycles.

Source files
------------

// File: rtl/sr_ff_arbiter.sv
// Round-robin arbiter/sequencer sharing one SR flip-flop bank among NREQ requesters.
// Latency: req to ack 2 cycles with SR_ARB_READBACK_EN (IDLE->ISSUE->CHECK), 1 cycle without.
// Backpressure: requesters hold req/op_set/mask until their ack; losers simply wait in IDLE.
// Optional macro SR_ARB_READBACK_EN adds the CHECK state and the q_in readback error flag.
module sr_ff_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op_set,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [WIDTH-1:0]      q_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      s_out,
  output logic [WIDTH-1:0]      r_out,
  output logic                  busy,
  output logic                  err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1
`ifdef SR_ARB_READBACK_EN
    ,
    ST_CHECK = 2'd2
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [WIDTH-1:0]  r_s;
  logic [WIDTH-1:0]  r_r;

  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;
  logic              w_win_vld;
  logic [PW-1:0]     w_win_idx;
  logic [NREQ-1:0]   w_win_onehot;
  logic [WIDTH-1:0]  w_win_mask;
  logic [PW-1:0]     w_ptr_nxt;

  // Rotate requests so the pointer position sits at bit 0; lowest set bit is the nearest winner.
  assign w_req_dbl = {req, req} >> r_ptr;
  assign w_req_rot = w_req_dbl[NREQ-1:0];

  // Priority pick of the first pending request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_off     = '0;
    w_win_vld = |w_req_rot;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off = PW'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(NREQ)) begin
      w_win_idx = PW'(w_sum - (PW+1)'(NREQ));
    end else begin
      w_win_idx = PW'(w_sum);
    end
  end

  assign w_win_onehot = NREQ'(1) << w_win_idx;
  assign w_win_mask   = mask[int'(w_win_idx)*WIDTH +: WIDTH];
  assign w_ptr_nxt    = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

`ifdef SR_ARB_READBACK_EN
  logic [PW-1:0]    r_idx;
  logic [WIDTH-1:0] w_chk_mask;
  logic [WIDTH-1:0] w_chk_hit;
  logic             w_chk_bad;

  // The granted requester's mask and op are still held stable, so check q_in against them.
  assign w_chk_mask = mask[int'(r_idx)*WIDTH +: WIDTH];
  assign w_chk_hit  = q_in & w_chk_mask;
  assign w_chk_bad  = op_set[r_idx] ? (w_chk_hit != w_chk_mask) : (w_chk_hit != '0);

  // Remember which requester owns the op so CHECK can index its mask and op.
  always_ff @(posedge clk) begin
    if (res) begin
      r_idx <= '0;
    end else if (r_state == ST_IDLE && w_win_vld) begin
      r_idx <= w_win_idx;
    end
  end
`else
  logic w_unused_q;
  assign w_unused_q = ^q_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE waits for a request, ISSUE lasts one cycle, CHECK lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef SR_ARB_READBACK_EN
        w_state_nxt = ST_CHECK;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
`ifdef SR_ARB_READBACK_EN
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered grant, s/r vectors and pointer; s and r are never both driven for the same op.
  always_ff @(posedge clk) begin
    if (res) begin
      r_gnt <= '0;
      r_s   <= '0;
      r_r   <= '0;
      r_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_gnt <= w_win_onehot;
            r_s   <= op_set[w_win_idx] ? w_win_mask : '0;
            r_r   <= op_set[w_win_idx] ? '0 : w_win_mask;
            r_ptr <= w_ptr_nxt;
          end
        end
        ST_ISSUE: begin
          r_s <= '0;
          r_r <= '0;
`ifndef SR_ARB_READBACK_EN
          r_gnt <= '0;
`endif
        end
`ifdef SR_ARB_READBACK_EN
        ST_CHECK: begin
          r_gnt <= '0;
        end
`endif
        default: begin
          r_gnt <= '0;
          r_s   <= '0;
          r_r   <= '0;
        end
      endcase
    end
  end

  // Output decode: ack is the grant during the final cycle of an op, err only during CHECK.
  always_comb begin
    busy = (r_state != ST_IDLE);
    ack  = '0;
    err  = 1'b0;
`ifdef SR_ARB_READBACK_EN
    if (r_state == ST_CHECK) begin
      ack = r_gnt;
      err = w_chk_bad;
    end
`else
    if (r_state == ST_ISSUE) begin
      ack = r_gnt;
    end
`endif
  end

  assign gnt   = r_gnt;
  assign s_out = r_s;
  assign r_out = r_r;

endmodule
